prv_trap_sequencer: RTL and testbench
=====================================

# prv_trap_sequencer

Sequences trap entry and trap return between the pipeline hazard unit and the privilege block. Collects the synchronous exception flags, pending interrupts and xRET requests. Selects one event by fixed priority and waits for the memory stage to drain. It then issues a single commit to the CSR logic and redirects fetch via `insert_pc`/`priv_pc`. It replaces ad-hoc trap muxing in the priv block with one explicit state machine.

## Interface
Parameters:
- `HOLDOFF_CYCLES`, 1, cycles after redirect during which all inputs are ignored (flushed-instruction flags); range 1–3.

Ports:
- `CLK` in 1: clock.
- `nRST` in 1: asynchronous, active-low reset.
- `fault_insn_page, fault_insn, illegal_insn, mal_insn, env, breakpoint, mal_s, mal_l, fault_store_page, fault_load_page, fault_s, fault_l` in 1 each: exception flags from the hazard unit.
- `mret, sret` in 1: xRET retiring.
- `intr_pending` in 1: enabled, unmasked interrupt pending (from CSR logic).
- `intr_cause` in 4: interrupt code.
- `curr_privilege_level` in 2: U=0, S=1, M=3.
- `epc` in 32: PC of the faulting/retiring instruction.
- `badaddr` in 32: faulting address.
- `ex_mem_stall` in 1: memory stage busy; no commit while high.
- `mtvec` in 32: trap vector; [1:0]=01 means vectored.
- `mepc_r, sepc_r` in 32: return targets.
- `trap_commit` out 1: one-cycle pulse; CSR logic updates mcause/mepc/mtval/mstatus.
- `xret_commit` out 1: one-cycle pulse; `xret_is_s` selects sret.
- `xret_is_s` out 1.
- `trap_is_intr` out 1, `trap_cause` out 4, `trap_epc` out 32, `trap_tval` out 32: latched, valid with `trap_commit`.
- `pipe_clear` out 1: flush request, concurrent with commit.
- `insert_pc` out 1, `priv_pc` out 32: fetch redirect.
- `busy` out 1: high in every non-IDLE state.

## Operation
- States: IDLE, DRAIN, COMMIT, REDIRECT, HOLDOFF.
- Event selection in IDLE, first match wins:
  - fault_insn_page (12)
  - fault_insn (1)
  - illegal_insn (2)
  - mal_insn (0)
  - env (8 + priv: U→8, S→9, M→11)
  - breakpoint (3)
  - mal_s (6)
  - mal_l (4)
  - fault_store_page (15)
  - fault_load_page (13)
  - fault_s (7)
  - fault_l (5)
  - mret
  - sret
  - intr_pending (cause = `intr_cause`, `trap_is_intr`=1)
- mret and sret together: mret wins.
- tval:
  - `badaddr` for page faults, access faults and misaligned.
  - `epc` for breakpoint.
  - 0 for illegal, env and interrupt.
- On selection in IDLE: latch kind/cause/epc/tval/target. Go to DRAIN if `ex_mem_stall`, else COMMIT.
- DRAIN: hold latched values; go to COMMIT the first cycle `ex_mem_stall`=0. New flags are ignored.
- COMMIT: assert `trap_commit` or `xret_commit` and `pipe_clear` for exactly one cycle; go to REDIRECT.
- REDIRECT: `insert_pc`=1 for one cycle with `priv_pc`; go to HOLDOFF.
- HOLDOFF: count `HOLDOFF_CYCLES`, then IDLE.
- Target selection:
  - Trap: `{mtvec[31:2],2'b00}`, plus `cause<<2` when vectored and interrupt.
  - mret: `mepc_r`. sret: `sepc_r`.
  - `mepc_r`/`sepc_r`/`mtvec` are sampled in COMMIT, so a same-cycle CSR write is seen.
- Arithmetic is 32-bit; vectored add wraps modulo 2^32.

## Timing
- Reset: all outputs 0, state IDLE, latches 0. Reset mid-sequence aborts; no commit or redirect pulse is emitted.
- Latency with no stall: event at cycle N, commit at N+1, `insert_pc` at N+2, IDLE at N+3+HOLDOFF_CYCLES.
- Each DRAIN cycle adds one cycle.
- Exactly one commit pulse and one `insert_pc` pulse per accepted event.
- Commit and redirect pulses are never simultaneous.
- Flags arriving in any non-IDLE state are dropped; the hazard unit re-raises if still valid.
- Interrupt pending during an exception: the exception is taken; the interrupt is re-evaluated in IDLE.
- Outputs are registered; no combinational input→output path except `busy` (state decode).

## Structure
- `priv_isa_types_pkg` gains:
  - `trap_seq_state_t` enum.
  - `trap_kind_t` (EXC, INTR, MRET, SRET).
  - Exception-code localparams (reuse existing `ex_code_t` if present).
- Sub-module `prv_trap_prio`: combinational priority encoder (flags + priv → valid, kind, cause, tval_sel).
- Top holds the FSM, latches and target computation.

## Test plan
- Single illegal_insn, `epc`=0x100, `mtvec`=0x8000_0000, no stall → `trap_commit` at N+1 with cause=2, tval=0, epc=0x100; `insert_pc` at N+2 with `priv_pc`=0x8000_0000.
- fault_l + mal_s together, `badaddr`=0x2003 → cause=6, tval=0x2003; exactly one commit.
- Timer interrupt, cause=7, `mtvec`=0x8000_0001 → `trap_is_intr`=1, `priv_pc`=0x8000_001C.
- mret with `ex_mem_stall` high 3 cycles, `mepc_r`=0x400 → `xret_commit` on the 1st cycle after stall drops; `priv_pc`=0x400; no `trap_commit`.
- env at priv U then M → cause 8 then 11. A second flag during HOLDOFF is ignored; re-raised flag accepted in IDLE.
- `nRST` low in DRAIN → all outputs 0 immediately; after release no stale commit or redirect occurs.

Source files
------------

// File: rtl/priv_isa_types_pkg.sv
// Shared privilege-ISA types: trap sequencer states, trap kinds, exception codes
// and the trap-vector target helper.
package priv_isa_types_pkg;

  typedef enum logic [2:0] {
    TS_IDLE     = 3'd0,
    TS_DRAIN    = 3'd1,
    TS_COMMIT   = 3'd2,
    TS_REDIRECT = 3'd3,
    TS_HOLDOFF  = 3'd4
  } trap_seq_state_t;

  typedef enum logic [1:0] {
    KIND_EXC  = 2'd0,
    KIND_INTR = 2'd1,
    KIND_MRET = 2'd2,
    KIND_SRET = 2'd3
  } trap_kind_t;

  typedef enum logic [1:0] {
    TVAL_ZERO    = 2'd0,
    TVAL_BADADDR = 2'd1,
    TVAL_EPC     = 2'd2
  } tval_sel_t;

  localparam logic [3:0] EX_MAL_INSN    = 4'd0;
  localparam logic [3:0] EX_FAULT_INSN  = 4'd1;
  localparam logic [3:0] EX_ILLEGAL     = 4'd2;
  localparam logic [3:0] EX_BREAKPOINT  = 4'd3;
  localparam logic [3:0] EX_MAL_L       = 4'd4;
  localparam logic [3:0] EX_FAULT_L     = 4'd5;
  localparam logic [3:0] EX_MAL_S       = 4'd6;
  localparam logic [3:0] EX_FAULT_S     = 4'd7;
  localparam logic [3:0] EX_ENV_U       = 4'd8;
  localparam logic [3:0] EX_INSN_PAGE   = 4'd12;
  localparam logic [3:0] EX_LOAD_PAGE   = 4'd13;
  localparam logic [3:0] EX_STORE_PAGE  = 4'd15;

  // Field order is the selection priority, highest first.
  typedef struct packed {
    logic fault_insn_page;
    logic fault_insn;
    logic illegal_insn;
    logic mal_insn;
    logic env;
    logic breakpoint;
    logic mal_s;
    logic mal_l;
    logic fault_store_page;
    logic fault_load_page;
    logic fault_s;
    logic fault_l;
  } exc_flags_t;

  // Only interrupts use the vectored offset; exceptions always land on the base.
  function automatic logic [31:0] trap_target(input logic [31:0] mtvec,
                                              input logic        is_intr,
                                              input logic [3:0]  cause);
    logic [31:0] base;
    base = {mtvec[31:2], 2'b00};
    if (is_intr && (mtvec[1:0] == 2'b01))
      base = base + {26'd0, cause, 2'b00};
    return base;
  endfunction

endpackage

// File: rtl/prv_trap_sequencer_if.sv
// Bundle between the hazard unit / CSR logic (master) and the trap sequencer (slave).
interface prv_trap_sequencer_if;
  logic        fault_insn_page, fault_insn, illegal_insn, mal_insn, env, breakpoint;
  logic        mal_s, mal_l, fault_store_page, fault_load_page, fault_s, fault_l;
  logic        mret, sret;
  logic        intr_pending;
  logic [3:0]  intr_cause;
  logic [1:0]  curr_privilege_level;
  logic [31:0] epc, badaddr;
  logic        ex_mem_stall;
  logic [31:0] mtvec, mepc_r, sepc_r;
  logic        trap_commit, xret_commit, xret_is_s;
  logic        trap_is_intr;
  logic [3:0]  trap_cause;
  logic [31:0] trap_epc, trap_tval;
  logic        pipe_clear, insert_pc;
  logic [31:0] priv_pc;
  logic        busy;

  modport master (
    output fault_insn_page, fault_insn, illegal_insn, mal_insn, env, breakpoint,
           mal_s, mal_l, fault_store_page, fault_load_page, fault_s, fault_l,
           mret, sret, intr_pending, intr_cause, curr_privilege_level,
           epc, badaddr, ex_mem_stall, mtvec, mepc_r, sepc_r,
    input  trap_commit, xret_commit, xret_is_s, trap_is_intr, trap_cause,
           trap_epc, trap_tval, pipe_clear, insert_pc, priv_pc, busy
  );

  modport slave (
    input  fault_insn_page, fault_insn, illegal_insn, mal_insn, env, breakpoint,
           mal_s, mal_l, fault_store_page, fault_load_page, fault_s, fault_l,
           mret, sret, intr_pending, intr_cause, curr_privilege_level,
           epc, badaddr, ex_mem_stall, mtvec, mepc_r, sepc_r,
    output trap_commit, xret_commit, xret_is_s, trap_is_intr, trap_cause,
           trap_epc, trap_tval, pipe_clear, insert_pc, priv_pc, busy
  );
endinterface

// File: rtl/prv_trap_prio.sv
// Fixed-priority selection of one trap/return event from the raw request flags.
module prv_trap_prio
  import priv_isa_types_pkg::*;
(
  input  exc_flags_t  flags,
  input  logic        mret,
  input  logic        sret,
  input  logic        intr_pending,
  input  logic [3:0]  intr_cause,
  input  logic [1:0]  priv,
  output logic        valid,
  output trap_kind_t  kind,
  output logic [3:0]  cause,
  output tval_sel_t   tval_sel
);

  always_comb begin
    valid    = 1'b1;
    kind     = KIND_EXC;
    cause    = 4'd0;
    tval_sel = TVAL_BADADDR;
    if (flags.fault_insn_page)       cause = EX_INSN_PAGE;
    else if (flags.fault_insn)       cause = EX_FAULT_INSN;
    else if (flags.illegal_insn) begin
      cause    = EX_ILLEGAL;
      tval_sel = TVAL_ZERO;
    end
    else if (flags.mal_insn)         cause = EX_MAL_INSN;
    else if (flags.env) begin
      // U/S/M map onto 8/9/11 because the privilege encoding skips 2.
      cause    = EX_ENV_U + {2'b00, priv};
      tval_sel = TVAL_ZERO;
    end
    else if (flags.breakpoint) begin
      cause    = EX_BREAKPOINT;
      tval_sel = TVAL_EPC;
    end
    else if (flags.mal_s)            cause = EX_MAL_S;
    else if (flags.mal_l)            cause = EX_MAL_L;
    else if (flags.fault_store_page) cause = EX_STORE_PAGE;
    else if (flags.fault_load_page)  cause = EX_LOAD_PAGE;
    else if (flags.fault_s)          cause = EX_FAULT_S;
    else if (flags.fault_l)          cause = EX_FAULT_L;
    else if (mret) begin
      kind     = KIND_MRET;
      tval_sel = TVAL_ZERO;
    end
    else if (sret) begin
      kind     = KIND_SRET;
      tval_sel = TVAL_ZERO;
    end
    else if (intr_pending) begin
      kind     = KIND_INTR;
      cause    = intr_cause;
      tval_sel = TVAL_ZERO;
    end
    else begin
      valid    = 1'b0;
      tval_sel = TVAL_ZERO;
    end
  end

endmodule

// File: rtl/prv_trap_sequencer.sv
// Trap entry / xRET sequencer: select one event, wait for the memory stage,
// emit a single CSR commit, redirect fetch, then hold off flushed flags.
module prv_trap_sequencer
  import priv_isa_types_pkg::*;
#(
  parameter int HOLDOFF_CYCLES = 1
) (
  input  logic                 CLK,
  input  logic                 nRST,
  prv_trap_sequencer_if.slave  bus
);

  localparam logic [2:0] S_IDLE     = TS_IDLE;
  localparam logic [2:0] S_DRAIN    = TS_DRAIN;
  localparam logic [2:0] S_COMMIT   = TS_COMMIT;
  localparam logic [2:0] S_REDIRECT = TS_REDIRECT;
  localparam logic [2:0] S_HOLDOFF  = TS_HOLDOFF;

  localparam logic [1:0] HOLD_LOAD = 2'(HOLDOFF_CYCLES - 1);

  exc_flags_t  flags;
  logic        sel_valid;
  trap_kind_t  sel_kind;
  logic [3:0]  sel_cause;
  tval_sel_t   sel_tval;

  logic [2:0]  state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  trap_kind_t  kind_q, kind_d;
  logic [3:0]  cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] tval_q, tval_d;
  logic [31:0] priv_pc_q, priv_pc_d;
  logic        trap_commit_q, trap_commit_d;
  logic        xret_commit_q, xret_commit_d;
  logic        pipe_clear_q, pipe_clear_d;
  logic        insert_pc_q, insert_pc_d;
  logic        fire;
  logic [31:0] target;

  assign flags = {bus.fault_insn_page, bus.fault_insn, bus.illegal_insn, bus.mal_insn,
                  bus.env, bus.breakpoint, bus.mal_s, bus.mal_l, bus.fault_store_page,
                  bus.fault_load_page, bus.fault_s, bus.fault_l};

  prv_trap_prio u_prio (
    .flags        (flags),
    .mret         (bus.mret),
    .sret         (bus.sret),
    .intr_pending (bus.intr_pending),
    .intr_cause   (bus.intr_cause),
    .priv         (bus.curr_privilege_level),
    .valid        (sel_valid),
    .kind         (sel_kind),
    .cause        (sel_cause),
    .tval_sel     (sel_tval)
  );

  // Return targets and mtvec are read live in COMMIT so a same-cycle CSR write lands.
  always_comb begin
    case (kind_q)
      KIND_MRET: target = bus.mepc_r;
      KIND_SRET: target = bus.sepc_r;
      default:   target = trap_target(bus.mtvec, kind_q == KIND_INTR, cause_q);
    endcase
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    kind_d        = kind_q;
    cause_d       = cause_q;
    epc_d         = epc_q;
    tval_d        = tval_q;
    priv_pc_d     = priv_pc_q;
    insert_pc_d   = 1'b0;
    fire          = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sel_valid) begin
          kind_d  = sel_kind;
          cause_d = sel_cause;
          epc_d   = bus.epc;
          case (sel_tval)
            TVAL_BADADDR: tval_d = bus.badaddr;
            TVAL_EPC:     tval_d = bus.epc;
            default:      tval_d = 32'd0;
          endcase
          if (bus.ex_mem_stall) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_COMMIT;
            fire    = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (!bus.ex_mem_stall) begin
          state_d = S_COMMIT;
          fire    = 1'b1;
        end
      end
      S_COMMIT: begin
        state_d     = S_REDIRECT;
        insert_pc_d = 1'b1;
        priv_pc_d   = target;
      end
      S_REDIRECT: begin
        state_d = S_HOLDOFF;
        cnt_d   = HOLD_LOAD;
      end
      S_HOLDOFF: begin
        if (cnt_q == 2'd0) state_d = S_IDLE;
        else               cnt_d   = cnt_q - 2'd1;
      end
      default: state_d = S_IDLE;
    endcase
    trap_commit_d = fire && ((kind_d == KIND_EXC) || (kind_d == KIND_INTR));
    xret_commit_d = fire && ((kind_d == KIND_MRET) || (kind_d == KIND_SRET));
    pipe_clear_d  = fire;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q       <= S_IDLE;
      cnt_q         <= 2'd0;
      kind_q        <= KIND_EXC;
      cause_q       <= 4'd0;
      epc_q         <= 32'd0;
      tval_q        <= 32'd0;
      priv_pc_q     <= 32'd0;
      trap_commit_q <= 1'b0;
      xret_commit_q <= 1'b0;
      pipe_clear_q  <= 1'b0;
      insert_pc_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      kind_q        <= kind_d;
      cause_q       <= cause_d;
      epc_q         <= epc_d;
      tval_q        <= tval_d;
      priv_pc_q     <= priv_pc_d;
      trap_commit_q <= trap_commit_d;
      xret_commit_q <= xret_commit_d;
      pipe_clear_q  <= pipe_clear_d;
      insert_pc_q   <= insert_pc_d;
    end
  end

  assign bus.trap_commit  = trap_commit_q;
  assign bus.xret_commit  = xret_commit_q;
  assign bus.xret_is_s    = (kind_q == KIND_SRET);
  assign bus.trap_is_intr = (kind_q == KIND_INTR);
  assign bus.trap_cause   = cause_q;
  assign bus.trap_epc     = epc_q;
  assign bus.trap_tval    = tval_q;
  assign bus.pipe_clear   = pipe_clear_q;
  assign bus.insert_pc    = insert_pc_q;
  assign bus.priv_pc      = priv_pc_q;
  assign bus.busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_prv_trap_sequencer.sv
// Bench for prv_trap_sequencer: directed vector table, hand-written multi-cycle
// sequences, and a randomized run against a transaction-level reference model.
module tb_prv_trap_sequencer;

  localparam int HOLD = 2;
  localparam int NR   = 400;
  localparam int NT   = NR + 40;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  prv_trap_sequencer_if ifc ();

  prv_trap_sequencer #(.HOLDOFF_CYCLES(HOLD)) dut (
    .CLK  (clk),
    .nRST (rst_n),
    .bus  (ifc.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", nm, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  // Flag bit j is the j-th entry of the priority list (bit 0 = fault_insn_page).
  task automatic drive(input logic [11:0] f, input logic mr, input logic sr, input logic ip,
                       input logic [3:0] ic, input logic [1:0] pv, input logic [31:0] ep,
                       input logic [31:0] ba, input logic [31:0] mt, input logic [31:0] me,
                       input logic [31:0] se, input logic st);
    ifc.fault_insn_page  = f[0];
    ifc.fault_insn       = f[1];
    ifc.illegal_insn     = f[2];
    ifc.mal_insn         = f[3];
    ifc.env              = f[4];
    ifc.breakpoint       = f[5];
    ifc.mal_s            = f[6];
    ifc.mal_l            = f[7];
    ifc.fault_store_page = f[8];
    ifc.fault_load_page  = f[9];
    ifc.fault_s          = f[10];
    ifc.fault_l          = f[11];
    ifc.mret = mr;
    ifc.sret = sr;
    ifc.intr_pending = ip;
    ifc.intr_cause = ic;
    ifc.curr_privilege_level = pv;
    ifc.epc = ep;
    ifc.badaddr = ba;
    ifc.mtvec = mt;
    ifc.mepc_r = me;
    ifc.sepc_r = se;
    ifc.ex_mem_stall = st;
  endtask

  task automatic clear_events();
    drive(12'h000, 1'b0, 1'b0, 1'b0, ifc.intr_cause, ifc.curr_privilege_level, ifc.epc,
          ifc.badaddr, ifc.mtvec, ifc.mepc_r, ifc.sepc_r, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, "_trap_commit"}, ifc.trap_commit, 1'b0);
    chk1({tag, "_xret_commit"}, ifc.xret_commit, 1'b0);
    chk1({tag, "_xret_is_s"}, ifc.xret_is_s, 1'b0);
    chk1({tag, "_trap_is_intr"}, ifc.trap_is_intr, 1'b0);
    chk32({tag, "_trap_cause"}, {28'd0, ifc.trap_cause}, 32'd0);
    chk32({tag, "_trap_epc"}, ifc.trap_epc, 32'd0);
    chk32({tag, "_trap_tval"}, ifc.trap_tval, 32'd0);
    chk1({tag, "_pipe_clear"}, ifc.pipe_clear, 1'b0);
    chk1({tag, "_insert_pc"}, ifc.insert_pc, 1'b0);
    chk32({tag, "_priv_pc"}, ifc.priv_pc, 32'd0);
    chk1({tag, "_busy"}, ifc.busy, 1'b0);
  endtask

  typedef struct {
    logic [11:0] fl;
    logic        mr, sr, ip;
    logic [3:0]  ic;
    logic [1:0]  pv;
    logic [31:0] ep, ba, mt, me, se;
    logic        x_xret, x_s, x_intr;
    logic [3:0]  x_cause;
    logic [31:0] x_tval, x_pc;
  } vec_t;

  vec_t vt [17];

  // Single event with no stall: commit at N+1, redirect at N+2, IDLE at N+3+HOLD.
  task automatic run_vec(input int id, input vec_t v);
    string p;
    p = $sformatf("vec%0d", id);
    @(negedge clk);
    drive(v.fl, v.mr, v.sr, v.ip, v.ic, v.pv, v.ep, v.ba, v.mt, v.me, v.se, 1'b0);
    @(negedge clk);
    clear_events();
    chk1({p, "_trap_commit"}, ifc.trap_commit, !v.x_xret);
    chk1({p, "_xret_commit"}, ifc.xret_commit, v.x_xret);
    chk1({p, "_pipe_clear"}, ifc.pipe_clear, 1'b1);
    chk1({p, "_insert_early"}, ifc.insert_pc, 1'b0);
    if (v.x_xret) begin
      chk1({p, "_xret_is_s"}, ifc.xret_is_s, v.x_s);
    end else begin
      chk32({p, "_cause"}, {28'd0, ifc.trap_cause}, {28'd0, v.x_cause});
      chk32({p, "_tval"}, ifc.trap_tval, v.x_tval);
      chk32({p, "_epc"}, ifc.trap_epc, v.ep);
      chk1({p, "_is_intr"}, ifc.trap_is_intr, v.x_intr);
    end
    @(negedge clk);
    chk1({p, "_insert_pc"}, ifc.insert_pc, 1'b1);
    chk32({p, "_priv_pc"}, ifc.priv_pc, v.x_pc);
    chk1({p, "_commit_gone"}, ifc.trap_commit | ifc.xret_commit, 1'b0);
    for (int h = 0; h < HOLD; h++) begin
      @(negedge clk);
      chk1({p, "_busy_hold"}, ifc.busy, 1'b1);
      chk1({p, "_insert_gone"}, ifc.insert_pc, 1'b0);
    end
    @(negedge clk);
    chk1({p, "_idle"}, ifc.busy, 1'b0);
  endtask

  // Randomized stimulus and expected outputs, one entry per cycle.
  logic [11:0] s_fl [NT];
  logic        s_mr [NT], s_sr [NT], s_ip [NT], s_st [NT];
  logic [3:0]  s_ic [NT];
  logic [1:0]  s_pv [NT];
  logic [31:0] s_ep [NT], s_ba [NT], s_mt [NT], s_me [NT], s_se [NT];
  logic        e_tc [NT], e_xc [NT], e_ins [NT], e_busy [NT], e_intr [NT], e_s [NT];
  logic [3:0]  e_cause [NT];
  logic [31:0] e_tval [NT], e_epc [NT], e_pc [NT];

  int code_tab [12] = '{12, 1, 2, 0, 8, 3, 6, 4, 15, 13, 7, 5};
  // 0: zero, 1: badaddr, 2: epc
  int tval_tab [12] = '{1, 1, 0, 1, 0, 2, 1, 1, 1, 1, 1, 1};

  // kind: 0 exception, 1 interrupt, 2 mret, 3 sret, -1 nothing
  task automatic ref_select(input int i, output int kind, output logic [3:0] cause,
                            output logic [31:0] tval);
    kind = -1; cause = 4'd0; tval = 32'd0;
    for (int j = 0; j < 12; j++) begin
      if (kind == -1 && s_fl[i][j]) begin
        kind  = 0;
        cause = 4'(code_tab[j] + ((j == 4) ? int'(s_pv[i]) : 0));
        tval  = (tval_tab[j] == 1) ? s_ba[i] : (tval_tab[j] == 2) ? s_ep[i] : 32'd0;
      end
    end
    if (kind == -1) begin
      if (s_mr[i])      kind = 2;
      else if (s_sr[i]) kind = 3;
      else if (s_ip[i]) begin
        kind  = 1;
        cause = s_ic[i];
      end
    end
  endtask

  task automatic build_random();
    int c, k, kind, t;
    logic [3:0] cause;
    logic [31:0] tval, base;
    for (int i = 0; i < NT; i++) begin
      s_fl[i] = 12'h000; s_mr[i] = 1'b0; s_sr[i] = 1'b0; s_ip[i] = 1'b0;
      if (i < NR && $urandom_range(0, 2) == 0) begin
        s_fl[i] = 12'($urandom) & 12'($urandom) & 12'($urandom);
        s_mr[i] = ($urandom_range(0, 4) == 0);
        s_sr[i] = ($urandom_range(0, 4) == 0);
        s_ip[i] = ($urandom_range(0, 2) == 0);
      end
      s_ic[i] = 4'($urandom);
      t = $urandom_range(0, 2);
      s_pv[i] = (t == 2) ? 2'd3 : 2'(t);
      s_ep[i] = $urandom; s_ba[i] = $urandom;
      s_mt[i] = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 1));
      s_me[i] = $urandom; s_se[i] = $urandom;
      s_st[i] = (i < NR) && ($urandom_range(0, 2) == 0);
      e_tc[i] = 1'b0; e_xc[i] = 1'b0; e_ins[i] = 1'b0; e_busy[i] = 1'b0;
      e_intr[i] = 1'b0; e_s[i] = 1'b0; e_cause[i] = 4'd0;
      e_tval[i] = 32'd0; e_epc[i] = 32'd0; e_pc[i] = 32'd0;
    end
    c = 0;
    while (c < NR) begin
      ref_select(c, kind, cause, tval);
      if (kind >= 0) begin
        k = c;
        while (s_st[k]) k++;
        e_tc[k+1]    = (kind <= 1);
        e_xc[k+1]    = (kind >= 2);
        e_s[k+1]     = (kind == 3);
        e_intr[k+1]  = (kind == 1);
        e_cause[k+1] = cause;
        e_tval[k+1]  = tval;
        e_epc[k+1]   = s_ep[c];
        base = s_mt[k+1] & 32'hFFFF_FFFC;
        if (kind == 1 && s_mt[k+1][1:0] == 2'b01) base = base + 32'(cause) * 32'd4;
        e_ins[k+2] = 1'b1;
        e_pc[k+2]  = (kind == 2) ? s_me[k+1] : (kind == 3) ? s_se[k+1] : base;
        for (int b = c + 1; b <= k + 2 + HOLD; b++) e_busy[b] = 1'b1;
        c = k + 3 + HOLD;
      end else begin
        c++;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(12'h000, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);

    //        fl       mr    sr    ip    ic     pv     ep            ba            mt            me            se            xret  s     intr  cause  tval          pc
    vt[0]  = '{12'h004, 1'b0, 1'b0, 1'b0, 4'd0,  2'd3, 32'h0000_0100, 32'h0000_DEAD, 32'h8000_0000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd2,  32'h0,         32'h8000_0000};
    vt[1]  = '{12'h840, 1'b0, 1'b0, 1'b0, 4'd0,  2'd3, 32'h0000_0200, 32'h0000_2003, 32'h8000_0000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd6,  32'h0000_2003, 32'h8000_0000};
    vt[2]  = '{12'h000, 1'b0, 1'b0, 1'b1, 4'd7,  2'd3, 32'h0000_0300, 32'h0000_1111, 32'h8000_0001, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 4'd7,  32'h0,         32'h8000_001C};
    vt[3]  = '{12'h010, 1'b0, 1'b0, 1'b0, 4'd0,  2'd0, 32'h0000_0400, 32'h0000_2222, 32'h8000_0000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd8,  32'h0,         32'h8000_0000};
    vt[4]  = '{12'h010, 1'b0, 1'b0, 1'b0, 4'd0,  2'd3, 32'h0000_0404, 32'h0000_2222, 32'h8000_0000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd11, 32'h0,         32'h8000_0000};
    vt[5]  = '{12'h010, 1'b0, 1'b0, 1'b0, 4'd0,  2'd1, 32'h0000_0408, 32'h0000_2222, 32'h8000_0000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd9,  32'h0,         32'h8000_0000};
    vt[6]  = '{12'h020, 1'b0, 1'b0, 1'b0, 4'd0,  2'd3, 32'h0000_0044, 32'h0000_3333, 32'h8000_0000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd3,  32'h0000_0044, 32'h8000_0000};
    vt[7]  = '{12'h000, 1'b1, 1'b1, 1'b0, 4'd0,  2'd3, 32'h0000_0500, 32'h0,         32'h8000_0000, 32'h400, 32'h500, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0,      32'h0000_0400};
    vt[8]  = '{12'h000, 1'b0, 1'b1, 1'b0, 4'd0,  2'd1, 32'h0000_0504, 32'h0,         32'h8000_0000, 32'h400, 32'h500, 1'b1, 1'b1, 1'b0, 4'd0, 32'h0,      32'h0000_0500};
    vt[9]  = '{12'h001, 1'b1, 1'b0, 1'b1, 4'd3,  2'd0, 32'h0000_0600, 32'h0000_7000, 32'h8000_0001, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd12, 32'h0000_7000, 32'h8000_0000};
    vt[10] = '{12'h000, 1'b0, 1'b0, 1'b1, 4'd15, 2'd3, 32'h0000_0700, 32'h0,         32'hFFFF_FFF1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 4'd15, 32'h0,         32'h0000_002C};
    vt[11] = '{12'h300, 1'b0, 1'b0, 1'b0, 4'd0,  2'd3, 32'h0000_0800, 32'h0000_1234, 32'h8000_0000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd15, 32'h0000_1234, 32'h8000_0000};
    vt[12] = '{12'hC00, 1'b0, 1'b0, 1'b0, 4'd0,  2'd3, 32'h0000_0900, 32'h0000_5678, 32'h8000_0000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd7,  32'h0000_5678, 32'h8000_0000};
    vt[13] = '{12'h280, 1'b0, 1'b0, 1'b0, 4'd0,  2'd3, 32'h0000_0A00, 32'h0000_9ABC, 32'h8000_0000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd4,  32'h0000_9ABC, 32'h8000_0000};
    vt[14] = '{12'h800, 1'b0, 1'b0, 1'b0, 4'd0,  2'd3, 32'h0000_0B00, 32'h0000_0DEF, 32'h8000_0000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd5,  32'h0000_0DEF, 32'h8000_0000};
    vt[15] = '{12'h00A, 1'b0, 1'b0, 1'b0, 4'd0,  2'd3, 32'h0000_0C00, 32'h0000_4444, 32'h8000_0000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd1,  32'h0000_4444, 32'h8000_0000};
    vt[16] = '{12'h008, 1'b0, 1'b0, 1'b0, 4'd0,  2'd3, 32'h0000_0D00, 32'h0000_5555, 32'h8000_0001, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd0,  32'h0000_5555, 32'h8000_0000};

    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_all_zero("post_reset");

    for (int i = 0; i < 17; i++) run_vec(i, vt[i]);

    // mret under a 3-cycle stall; mepc_r changes only in the COMMIT cycle.
    @(negedge clk);
    drive(12'h000, 1'b1, 1'b0, 1'b0, 4'd0, 2'd3, 32'h40, 32'h0, 32'h8000_0000, 32'h300, 32'h0, 1'b1);
    for (int s = 1; s <= 3; s++) begin
      @(negedge clk);
      ifc.mret = 1'b0;
      chk1($sformatf("stall_xret_early%0d", s), ifc.xret_commit, 1'b0);
      chk1($sformatf("stall_busy%0d", s), ifc.busy, 1'b1);
      if (s == 3) ifc.ex_mem_stall = 1'b0;
    end
    @(negedge clk);
    chk1("stall_xret_commit", ifc.xret_commit, 1'b1);
    chk1("stall_no_trap", ifc.trap_commit, 1'b0);
    chk1("stall_xret_is_s", ifc.xret_is_s, 1'b0);
    ifc.mepc_r = 32'h400;
    @(negedge clk);
    chk1("stall_insert", ifc.insert_pc, 1'b1);
    chk32("stall_priv_pc", ifc.priv_pc, 32'h400);
    chk1("stall_no_trap2", ifc.trap_commit | ifc.xret_commit, 1'b0);
    repeat (HOLD + 1) @(negedge clk);
    chk1("stall_idle", ifc.busy, 1'b0);

    // A flag raised during HOLDOFF is dropped; re-raised in IDLE it is taken.
    drive(12'h010, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 32'h88, 32'h0, 32'h8000_0000, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    clear_events();
    chk1("hold_commit", ifc.trap_commit, 1'b1);
    chk32("hold_cause", {28'd0, ifc.trap_cause}, 32'd8);
    @(negedge clk);
    chk1("hold_insert", ifc.insert_pc, 1'b1);
    @(negedge clk);
    ifc.illegal_insn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    ifc.illegal_insn = 1'b0;
    chk1("hold_idle", ifc.busy, 1'b0);
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      chk1($sformatf("hold_dropped%0d", s), ifc.trap_commit | ifc.busy, 1'b0);
    end
    run_vec(100, vt[0]);

    // Reset while draining aborts the sequence without any pulse.
    @(negedge clk);
    drive(12'h004, 1'b0, 1'b0, 1'b0, 4'd0, 2'd3, 32'h123, 32'h0, 32'h8000_0000, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    clear_events();
    ifc.ex_mem_stall = 1'b1;
    chk1("rst_drain_busy", ifc.busy, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    ifc.ex_mem_stall = 1'b0;
    for (int s = 0; s < 6; s++) begin
      @(negedge clk);
      chk1($sformatf("rst_no_commit%0d", s), ifc.trap_commit | ifc.xret_commit, 1'b0);
      chk1($sformatf("rst_no_insert%0d", s), ifc.insert_pc, 1'b0);
      chk1($sformatf("rst_no_busy%0d", s), ifc.busy, 1'b0);
    end

    build_random();
    for (int i = 0; i < NT; i++) begin
      @(negedge clk);
      chk1($sformatf("rnd_trap_commit@%0d", i), ifc.trap_commit, e_tc[i]);
      chk1($sformatf("rnd_xret_commit@%0d", i), ifc.xret_commit, e_xc[i]);
      chk1($sformatf("rnd_pipe_clear@%0d", i), ifc.pipe_clear, e_tc[i] | e_xc[i]);
      chk1($sformatf("rnd_insert_pc@%0d", i), ifc.insert_pc, e_ins[i]);
      chk1($sformatf("rnd_busy@%0d", i), ifc.busy, e_busy[i]);
      if (e_tc[i]) begin
        chk32($sformatf("rnd_cause@%0d", i), {28'd0, ifc.trap_cause}, {28'd0, e_cause[i]});
        chk32($sformatf("rnd_tval@%0d", i), ifc.trap_tval, e_tval[i]);
        chk32($sformatf("rnd_epc@%0d", i), ifc.trap_epc, e_epc[i]);
        chk1($sformatf("rnd_is_intr@%0d", i), ifc.trap_is_intr, e_intr[i]);
      end
      if (e_xc[i]) chk1($sformatf("rnd_xret_is_s@%0d", i), ifc.xret_is_s, e_s[i]);
      if (e_ins[i]) chk32($sformatf("rnd_priv_pc@%0d", i), ifc.priv_pc, e_pc[i]);
      drive(s_fl[i], s_mr[i], s_sr[i], s_ip[i], s_ic[i], s_pv[i], s_ep[i], s_ba[i],
            s_mt[i], s_me[i], s_se[i], s_st[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
